// File: rtl/axis_video_pattern_gen.sv
// AXI-Stream video test-pattern source: emits H_ACTIVE x V_ACTIVE raster frames
// with tuser on pixel (0,0) and tlast on the last pixel of every line.
module axis_video_pattern_gen #(
    parameter int D_WIDTH  = 8,
    parameter int H_ACTIVE = 8,
    parameter int V_ACTIVE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [1:0]         pattern_sel,
    output logic [D_WIDTH-1:0] m_data,
    output logic               m_valid,
    output logic               m_tlast,
    output logic               m_tuser,
    input  logic               m_ready,
    output logic               frame_done,
    output logic               busy
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    if ((H_ACTIVE < 2) || (H_ACTIVE % 2 != 0)) begin : g_bad_h_active
        $error("axis_video_pattern_gen: H_ACTIVE must be even and >= 2");
    end
    if ((V_ACTIVE < 2) || (V_ACTIVE % 2 != 0)) begin : g_bad_v_active
        $error("axis_video_pattern_gen: V_ACTIVE must be even and >= 2");
    end

    // IDLE   | no stream, waiting for enable
    // ACTIVE | presenting beats of a frame; m_valid held high until frame end
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t             state, state_nxt;
    logic [XW-1:0]      x, x_nxt, x_adv;
    logic [YW-1:0]      y, y_nxt, y_adv;
    logic [D_WIDTH-1:0] frame_cnt, frame_cnt_nxt, frame_cnt_inc;
    logic [1:0]         pat, pat_nxt;
    logic [D_WIDTH-1:0] data_nxt;
    logic               valid_nxt, tlast_nxt, tuser_nxt, done_nxt, busy_nxt;
    logic               last_px;

    function automatic logic [D_WIDTH-1:0] pixel(input logic [XW-1:0] px,
                                                 input logic [YW-1:0] py,
                                                 input logic [1:0] p,
                                                 input logic [D_WIDTH-1:0] fc);
        logic [D_WIDTH-1:0] v;
        case (p)
            2'd0:    v = D_WIDTH'(px);
            2'd1:    v = D_WIDTH'(py);
            2'd2:    v = {D_WIDTH{px[0] ^ py[0]}};
            default: v = fc;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            frame_cnt  <= '0;
            pat        <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_tlast    <= 1'b0;
            m_tuser    <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            x          <= x_nxt;
            y          <= y_nxt;
            frame_cnt  <= frame_cnt_nxt;
            pat        <= pat_nxt;
            m_data     <= data_nxt;
            m_valid    <= valid_nxt;
            m_tlast    <= tlast_nxt;
            m_tuser    <= tuser_nxt;
            frame_done <= done_nxt;
            busy       <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        x_nxt         = x;
        y_nxt         = y;
        frame_cnt_nxt = frame_cnt;
        pat_nxt       = pat;
        data_nxt      = m_data;
        valid_nxt     = m_valid;
        tlast_nxt     = m_tlast;
        tuser_nxt     = m_tuser;
        done_nxt      = 1'b0;
        busy_nxt      = busy;

        last_px       = (x == X_LAST) && (y == Y_LAST);
        frame_cnt_inc = frame_cnt + D_WIDTH'(1);
        if (x == X_LAST) begin
            x_adv = '0;
            y_adv = y + YW'(1);
        end else begin
            x_adv = x + XW'(1);
            y_adv = y;
        end

        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                busy_nxt  = 1'b0;
                if (enable) begin
                    state_nxt = ACTIVE;
                    pat_nxt   = pattern_sel;
                    x_nxt     = '0;
                    y_nxt     = '0;
                    data_nxt  = pixel('0, '0, pattern_sel, frame_cnt);
                    valid_nxt = 1'b1;
                    tuser_nxt = 1'b1;
                    tlast_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            ACTIVE: begin
                if (m_ready) begin
                    if (last_px) begin
                        done_nxt      = 1'b1;
                        frame_cnt_nxt = frame_cnt_inc;
                        x_nxt         = '0;
                        y_nxt         = '0;
                        if (enable) begin
                            // back-to-back frame: flat pattern must see the new count
                            pat_nxt   = pattern_sel;
                            data_nxt  = pixel('0, '0, pattern_sel, frame_cnt_inc);
                            tuser_nxt = 1'b1;
                            tlast_nxt = 1'b0;
                        end else begin
                            state_nxt = IDLE;
                            data_nxt  = '0;
                            valid_nxt = 1'b0;
                            tuser_nxt = 1'b0;
                            tlast_nxt = 1'b0;
                            busy_nxt  = 1'b0;
                        end
                    end else begin
                        x_nxt     = x_adv;
                        y_nxt     = y_adv;
                        data_nxt  = pixel(x_adv, y_adv, pat, frame_cnt);
                        tuser_nxt = (x_adv == '0) && (y_adv == '0);
                        tlast_nxt = (x_adv == X_LAST);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Directed sequence with randomized backpressure; every beat is compared
// against a pixel model computed from the beat's position in the frame.
module tb_axis_video_pattern_gen;

    localparam int D_WIDTH = 8;
    localparam int H       = 8;
    localparam int V       = 4;
    localparam int FRAME   = H * V;
    localparam int MASK    = (1 << D_WIDTH) - 1;

    logic               clk;
    logic               rst;
    logic               enable;
    logic [1:0]         pattern_sel;
    logic [D_WIDTH-1:0] m_data;
    logic               m_valid;
    logic               m_tlast;
    logic               m_tuser;
    logic               m_ready;
    logic               frame_done;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    axis_video_pattern_gen #(
        .D_WIDTH (D_WIDTH),
        .H_ACTIVE(H),
        .V_ACTIVE(V)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .pattern_sel(pattern_sel),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_tlast    (m_tlast),
        .m_tuser    (m_tuser),
        .m_ready    (m_ready),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Beat k of a frame sits at x = k mod H, y = k div H.
    function automatic int exp_data(input int pat, input int k, input int fc);
        int px, py;
        px = k % H;
        py = k / H;
        case (pat)
            0:       return px & MASK;
            1:       return py & MASK;
            2:       return (((px ^ py) & 1) != 0) ? MASK : 0;
            default: return fc & MASK;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_data"}, m_data, 0);
        chk({tag, "_tlast"}, m_tlast, 0);
        chk({tag, "_tuser"}, m_tuser, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Called with beat 0 of a frame already presented. Walks the frame under
    // ready_pct% backpressure; optional enable drop, pattern_sel change, early stop.
    task automatic stream_frame(input int pat, input int fc, input int ready_pct,
                                input int drop_at, input int sel_at,
                                input logic [1:0] sel_val, input int stop_at);
        int   k   = 0;
        int   cyc = 0;
        logic xfer;
        while (k < FRAME) begin
            if (k == stop_at) return;
            chk("valid", m_valid, 1);
            chk("data", m_data, exp_data(pat, k, fc));
            chk("tuser", m_tuser, (k == 0));
            chk("tlast", m_tlast, ((k % H) == H - 1));
            chk("busy", busy, 1);
            if (k > 0) chk("done_mid", frame_done, 0);
            if (k == drop_at) enable = 1'b0;
            if (k == sel_at) pattern_sel = sel_val;
            m_ready = ($urandom_range(99) < ready_pct);
            xfer = m_ready;
            tick();
            if (xfer) k++;
            cyc++;
            if (cyc > 4000) begin
                chk("timeout", 0, 1);
                return;
            end
        end
        chk("frame_done", frame_done, 1);
        chk("valid_after", m_valid, enable);
        chk("busy_after", busy, enable);
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        pattern_sel = 2'd0;
        m_ready     = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk("idle_valid", m_valid, 0);

        // Pattern 0, ready always high: latency 1, then two back-to-back frames.
        enable      = 1'b1;
        pattern_sel = 2'd0;
        m_ready     = 1'b1;
        chk("pre_enable_valid", m_valid, 0);
        tick();
        chk("latency_valid", m_valid, 1);
        stream_frame(0, 0, 100, -1, -1, 2'd0, -1);
        pattern_sel = 2'd2;
        stream_frame(0, 1, 50, -1, -1, 2'd0, -1);

        // Checkerboard, enable dropped at beat 10, mid-frame sel change ignored.
        stream_frame(2, 2, 100, 10, 10, 2'd3, -1);
        repeat (3) begin
            tick();
            chk("idle_after_drop", m_valid, 0);
            chk("idle_busy", busy, 0);
        end

        rst = 1'b1;
        tick();
        chk_all_zero("reset2");
        rst = 1'b0;

        // Flat pattern over three frames carries frame count 0,1,2.
        enable      = 1'b1;
        pattern_sel = 2'd3;
        tick();
        stream_frame(3, 0, 60, -1, -1, 2'd0, -1);
        stream_frame(3, 1, 60, -1, -1, 2'd0, -1);
        stream_frame(3, 2, 60, -1, 16, 2'd0, -1);
        stream_frame(0, 3, 60, -1, -1, 2'd0, 13);

        // Reset mid-frame at beat 13.
        rst     = 1'b1;
        m_ready = 1'b0;
        tick();
        chk_all_zero("midrst");
        pattern_sel = 2'd3;
        rst         = 1'b0;
        tick();
        stream_frame(3, 0, 70, 5, -1, 2'd0, -1);
        tick();
        chk("final_idle", m_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
